// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, coordinate type and decode helper.
// Shared by the timing generator and the renderers (H_DISPLAY/V_DISPLAY).
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int CLK_DIV = 4;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
    logic frame_start;
  } raster_ctl_t;

  function automatic logic in_span(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate enable: one-clk pixel_tick every CLK_DIV system clocks.
// Ports: clk, rst_n (async, active-low) -> pixel_tick.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_LAST) begin
      div_nxt = '0;
    end
  end

  // pixel_tick is registered from the next count so it is
  // high exactly while div_cnt == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      pixel_tick <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      pixel_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters, video_on, hsync/vsync, frame_start.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        pixel_tick,
  output logic [vga_pkg::COORD_W-1:0] x,
  output logic [vga_pkg::COORD_W-1:0] y,
  output logic                        video_on,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]                  frame_cnt
`endif
);

  import vga_pkg::*;

  localparam int HT =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_DISP = coord_t'(H_DISPLAY);
  localparam coord_t V_DISP = coord_t'(V_DISPLAY);

  localparam coord_t HS_LO =
    coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_HI =
    coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO =
    coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_HI =
    coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick)
  );

  coord_t      x_nxt;
  coord_t      y_nxt;
  raster_ctl_t ctl_nxt;

  // Decode is taken from the next coordinates so that the
  // registered sync/blank flags land on the same edge as x/y.
  always_comb begin
    x_nxt   = x + coord_t'(1);
    y_nxt   = y;
    ctl_nxt = '0;
    if (x == H_LAST) begin
      x_nxt = '0;
      if (y == V_LAST) begin
        y_nxt = '0;
      end else begin
        y_nxt = y + coord_t'(1);
      end
    end
    ctl_nxt.video_on =
      (x_nxt < H_DISP) && (y_nxt < V_DISP);
    ctl_nxt.hsync =
      !in_span(x_nxt, HS_LO, HS_HI);
    ctl_nxt.vsync =
      !in_span(y_nxt, VS_LO, VS_HI);
    ctl_nxt.frame_start =
      (x_nxt == '0) && (y_nxt == '0);
  end

  // Reset parks the raster on its last position so the first
  // tick wraps straight into (0,0) and raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= H_LAST;
      y           <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pixel_tick) begin
        x           <= x_nxt;
        y           <= y_nxt;
        video_on    <= ctl_nxt.video_on;
        hsync       <= ctl_nxt.hsync;
        vsync       <= ctl_nxt.vsync;
        frame_start <= ctl_nxt.frame_start;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
